tetris_seq_ctrl: RTL
====================

# tetris_seq_ctrl

- Central game sequencer for the Tetris chip.
- Generates the 3-bit `state` code and registered `curr_piece` consumed by `clear_redraw` and the move datapath.
- Times gravity steps and gates user moves to the MOVE phase.
- Waits on the clear/redraw handshake, keeps the line score, and detects game over from spawn collision or clear errors.

## Interface
- DROP_TICKS, 8, MOVE-state cycles between gravity steps; legal range 1..255.
- SCORE_W, 16, score counter width.
- clka  in  1  system clock; all logic on rising edge.
- restart_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a game; honoured only in IDLE or OVER.
- rand_piece  in  2  piece id from the generator; sampled in GEN.
- spawn_blocked  in  1  spawn area occupied; sampled in GEN.
- user_move  in  2  00 none, 01 left, 10 right, 11 rotate.
- blocked_vld  in  1  move-datapath response strobe for a step_down.
- blocked  in  1  with blocked_vld: 1 means the piece cannot descend.
- clear_done  in  1  one-cycle pulse: clear_redraw has finished the pass.
- lines  in  3  rows cleared (0..4); valid with clear_done.
- clr_error  in  1  error from clear_redraw.
- state  out  3  game state code, registered.
- curr_piece  out  2  latched piece id, registered.
- step_down  out  1  one-cycle gravity request pulse.
- move_cmd  out  2  forwarded user move, registered, one cycle per move.
- score  out  SCORE_W  total lines cleared; saturating.
- game_over  out  1  high while in OVER.

## Operation
- State codes: GEN 000, MOVE 001, LOCK 010, CLEAR 011, OVER 100, DROP 110, IDLE 111.
- IDLE:
  - start=1 → GEN.
  - score cleared on this transition.
- GEN (one cycle):
  - curr_piece ← rand_piece.
  - drop counter ← DROP_TICKS-1.
  - spawn_blocked=1 → OVER; otherwise → MOVE.
- MOVE:
  - Drop counter decrements each cycle.
  - Counter at 0 → DROP, counter reloads, step_down=1 in the first DROP cycle.
  - Counter not 0 and user_move≠00 → move_cmd=user_move next cycle; otherwise move_cmd=00.
  - Moves arriving outside MOVE, or in the cycle the counter is 0, are dropped, not queued.
- DROP:
  - Holds until blocked_vld=1.
  - blocked=1 → LOCK; blocked=0 → MOVE.
  - blocked_vld in the same cycle as step_down is ignored; the response is only accepted from the following cycle.
- LOCK (one cycle; the board merges the piece) → CLEAR.
- CLEAR:
  - Holds until clear_done or clr_error.
  - clear_done → score += lines, saturating at all-ones, then → GEN.
  - clr_error has priority: → OVER, score unchanged.
- OVER:
  - game_over=1.
  - start=1 → GEN; score cleared.
- start in any other state is ignored.
- Illegal state codes (101) → IDLE on the next edge.

## Timing
- Reset values, applied asynchronously when restart_n=0:
  - state 111 (IDLE), curr_piece 00, step_down 0, move_cmd 00, score 0, game_over 0.
  - Internal drop counter 0.
- All outputs are registered; each is derived from the next state, so it is valid in the same cycle the FSM enters a state.
- Gravity period:
  - With blocked=0 returned one cycle after step_down, consecutive step_down pulses are DROP_TICKS+2 cycles apart.
  - DROP_TICKS=1 → period 3.
- LOCK → CLEAR → GEN adds 2 cycles plus the clear_redraw latency.
- Reset asserted mid-game (any state, pending handshake) returns to IDLE at once.
  - A later blocked_vld or clear_done is ignored outside DROP/CLEAR.
- Score saturation: at 16'hFFFE, lines=3 → 16'hFFFF.

## Structure
- tetris_pkg holds:
  - state codes (ST_GEN, ST_MOVE, ST_LOCK, ST_CLEAR, ST_OVER, ST_DROP, ST_IDLE);
  - piece ids;
  - move codes (MV_NONE, MV_LEFT, MV_RIGHT, MV_ROT).
- clear_redraw and the move datapath share this package.
- One sub-module, drop_timer:
  - a loadable down-counter of width $clog2(DROP_TICKS+1) with a zero flag;
  - reload and enable are driven by the FSM.
- The FSM, score, and output registers stay in the top module.

## Test plan
- Reset then start, rand_piece=10, spawn_blocked=0 → state 000 then 001; curr_piece=10; step_down pulses in the DROP_TICKS+1 cycle after MOVE entry.
- DROP_TICKS=4, blocked_vld/blocked=0 one cycle after each step_down → pulse spacing 6 cycles; after blocked=1 → 010 then 011.
- In CLEAR, clear_done with lines=3, then lines=4 → score 3 then 7; state 000 after each.
- clr_error and clear_done in the same cycle → state 100, game_over=1, score unchanged; then start → 000 with score 0.
- user_move=01 held for 3 MOVE cycles, then during DROP → move_cmd=01 for 3 cycles, then 00 throughout DROP.
- restart_n low mid-DROP and mid-CLEAR → all outputs at reset values immediately; a stale blocked_vld after release leaves state at 111.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris game sequencer, clear_redraw and the move datapath.
package tetris_pkg;

    // Game state codes as seen on the sequencer's 3-bit state output.
    typedef enum logic [2:0] {
        ST_GEN   = 3'b000,
        ST_MOVE  = 3'b001,
        ST_LOCK  = 3'b010,
        ST_CLEAR = 3'b011,
        ST_OVER  = 3'b100,
        ST_DROP  = 3'b110,
        ST_IDLE  = 3'b111
    } state_t;

    // Piece identifiers delivered by the random piece generator.
    typedef enum logic [1:0] {
        PC_I = 2'b00,
        PC_O = 2'b01,
        PC_T = 2'b10,
        PC_L = 2'b11
    } piece_t;

    // User move codes forwarded to the move datapath.
    typedef enum logic [1:0] {
        MV_NONE  = 2'b00,
        MV_LEFT  = 2'b01,
        MV_RIGHT = 2'b10,
        MV_ROT   = 2'b11
    } move_t;

    // Largest number of rows a single clear pass can remove.
    localparam int MAX_LINES = 4;

endpackage

// File: rtl/tetris_seq_ctrl_drop_timer.sv
// Gravity timer: loadable down-counter that parks at zero and flags it.
module drop_timer #(
    parameter int DROP_TICKS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    input  logic enable,
    output logic zero
);
    localparam int CW = $clog2(DROP_TICKS + 1);
    localparam logic [CW-1:0] RELOAD_VAL = CW'(DROP_TICKS - 1);

    logic [CW-1:0] count_reg;

    // Reload has priority; otherwise count down while enabled and not yet at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (reload) begin
            count_reg <= RELOAD_VAL;
        end else if (enable && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/tetris_seq_ctrl.sv
// Central game sequencer: piece spawn, gravity timing, move gating,
// clear/redraw handshake, line score and game-over detection.
module tetris_seq_ctrl
    import tetris_pkg::*;
#(
    parameter int DROP_TICKS = 8,
    parameter int SCORE_W    = 16
) (
    input  logic               clka,
    input  logic               restart_n,
    input  logic               start,
    input  logic [1:0]         rand_piece,
    input  logic               spawn_blocked,
    input  logic [1:0]         user_move,
    input  logic               blocked_vld,
    input  logic               blocked,
    input  logic               clear_done,
    input  logic [2:0]         lines,
    input  logic               clr_error,
    output logic [2:0]         state,
    output logic [1:0]         curr_piece,
    output logic               step_down,
    output logic [1:0]         move_cmd,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    state_t             state_reg, state_next;
    logic [1:0]         curr_piece_reg, curr_piece_next;
    logic               step_down_reg, step_down_next;
    logic [1:0]         move_cmd_reg, move_cmd_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic               game_over_reg;

    logic               timer_reload;
    logic               timer_enable;
    logic               timer_zero;

    // Score plus the rows just cleared, one bit wider so overflow is visible.
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;

    assign score_sum = {1'b0, score_reg} + {{(SCORE_W-2){1'b0}}, lines};
    assign score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    drop_timer #(
        .DROP_TICKS (DROP_TICKS)
    ) u_drop_timer (
        .clk    (clka),
        .rst_n  (restart_n),
        .reload (timer_reload),
        .enable (timer_enable),
        .zero   (timer_zero)
    );

    // Next-state logic plus the next value of every registered output.
    always_comb begin
        state_next      = state_reg;
        curr_piece_next = curr_piece_reg;
        step_down_next  = 1'b0;
        move_cmd_next   = MV_NONE;
        score_next      = score_reg;
        timer_reload    = 1'b0;
        timer_enable    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_GEN;
                    score_next = '0;
                end
            end
            ST_GEN: begin
                curr_piece_next = rand_piece;
                timer_reload    = 1'b1;
                state_next      = spawn_blocked ? ST_OVER : ST_MOVE;
            end
            ST_MOVE: begin
                // A move coinciding with the gravity step is discarded.
                if (timer_zero) begin
                    state_next     = ST_DROP;
                    timer_reload   = 1'b1;
                    step_down_next = 1'b1;
                end else begin
                    timer_enable  = 1'b1;
                    move_cmd_next = user_move;
                end
            end
            ST_DROP: begin
                // step_down_reg marks the request cycle; a response then is stale.
                if (blocked_vld && !step_down_reg) begin
                    state_next = blocked ? ST_LOCK : ST_MOVE;
                end
            end
            ST_LOCK: begin
                state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (clr_error) begin
                    state_next = ST_OVER;
                end else if (clear_done) begin
                    score_next = score_sat;
                    state_next = ST_GEN;
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_next = ST_GEN;
                    score_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers, all loaded from the next-state values.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_reg      <= ST_IDLE;
            curr_piece_reg <= 2'b00;
            step_down_reg  <= 1'b0;
            move_cmd_reg   <= MV_NONE;
            score_reg      <= '0;
            game_over_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            curr_piece_reg <= curr_piece_next;
            step_down_reg  <= step_down_next;
            move_cmd_reg   <= move_cmd_next;
            score_reg      <= score_next;
            game_over_reg  <= (state_next == ST_OVER);
        end
    end

    assign state      = state_reg;
    assign curr_piece = curr_piece_reg;
    assign step_down  = step_down_reg;
    assign move_cmd   = move_cmd_reg;
    assign score      = score_reg;
    assign game_over  = game_over_reg;

endmodule
